// File: rtl/cmd_parser.sv
// -----------------------------------------------------------------------------
// cmd_parser
//
// Byte-stream command parser. Bytes arrive as rx_data qualified by the rising
// edge of the level strobe rx_done. A header selects either a picture transfer
// (fixed-length payload forwarded with pay_last on the final byte) or game mode
// (bytes forwarded until the picture header or the SHOW_BYTE exit byte).
//
// Optional feature: define CMD_PARSER_TIMEOUT_EN to build the inter-byte
// timeout. When undefined there is no timer logic, tmo is tied low and the
// header/payload states wait indefinitely for the next byte.
//
// Parameters
//   DATA_W    byte width
//   HDR_LEN   header length in bytes (1..4)
//   HDR_PIC   picture header, first byte in the MSBs
//   HDR_GAME  game header, first byte must differ from HDR_PIC's first byte
//   SHOW_BYTE byte that leaves game mode for show mode
//   PAY_LEN   picture payload length in bytes (1..65535)
//   TMO_CYC   inter-byte timeout in cycles (>= 2)
//
// Ports
//   sys_clk    in   sole clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   rx_data    in   received byte, stable from rx_done rise until accepted
//   rx_done    in   level strobe, rising edge marks a new byte
//   mode       out  0=READY 1=PRECV 2=GAME 3=SHOW (registered)
//   pay_valid  out  one-cycle pulse, pay_data valid
//   pay_data   out  forwarded byte, holds when pay_valid is low
//   pay_last   out  with pay_valid on the final picture byte
//   hdr_err    out  one-cycle pulse on header mismatch
//   tmo        out  one-cycle pulse on timeout abort
// -----------------------------------------------------------------------------
module cmd_parser #(
  parameter int                          DATA_W    = 8,
  parameter int                          HDR_LEN   = 3,
  parameter logic [HDR_LEN*DATA_W-1:0]   HDR_PIC   = 24'hAABBCC,
  parameter logic [HDR_LEN*DATA_W-1:0]   HDR_GAME  = 24'hEEDDCC,
  parameter logic [DATA_W-1:0]           SHOW_BYTE = 8'hFF,
  parameter int                          PAY_LEN   = 1024,
  parameter int                          TMO_CYC   = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [1:0]        mode,
  output logic              pay_valid,
  output logic [DATA_W-1:0] pay_data,
  output logic              pay_last,
  output logic              hdr_err,
  output logic              tmo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_P,
    S_HDR_G,
    S_RECV,
    S_GAME,
    S_SHOW
  } state_t;

  localparam logic [1:0]  LAST_IDX = 2'(HDR_LEN - 1);
  localparam logic [15:0] LAST_CNT = 16'(PAY_LEN - 1);

  // Header bytes unpacked into per-index tables; unused slots (HDR_LEN < 4)
  // read as zero and are never reached because idx stops at LAST_IDX.
  logic [DATA_W-1:0] pic_bytes  [4];
  logic [DATA_W-1:0] game_bytes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hdr
      if (gi < HDR_LEN) begin : g_used
        assign pic_bytes[gi]  = HDR_PIC[(HDR_LEN-1-gi)*DATA_W +: DATA_W];
        assign game_bytes[gi] = HDR_GAME[(HDR_LEN-1-gi)*DATA_W +: DATA_W];
      end else begin : g_unused
        assign pic_bytes[gi]  = '0;
        assign game_bytes[gi] = '0;
      end
    end
  endgenerate

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              rx_done_q;
  logic              rx_seen_q;
  logic [1:0]        mode_q, mode_d;
  logic              pay_valid_q, pay_valid_d;
  logic [DATA_W-1:0] pay_data_q, pay_data_d;
  logic              pay_last_q, pay_last_d;
  logic              hdr_err_q, hdr_err_d;
  logic              tmo_q, tmo_d;

  logic accept;
  logic timed;
  logic tmo_expire;

  // Two-stage sample of rx_done: rx_done_q is this cycle's sample and
  // rx_seen_q the one before; a 0->1 step between them accepts rx_data.
  assign accept = rx_done_q & ~rx_seen_q;
  assign timed  = (state_q == S_HDR_P) || (state_q == S_HDR_G) ||
                  (state_q == S_RECV);

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter holds the number of byte-less cycles already elapsed in a
  // timed state. Expiry is suppressed whenever a byte is accepted, so a byte
  // arriving on the expiry cycle is processed normally instead.
  always_comb begin
    tmo_cnt_d  = '0;
    tmo_expire = 1'b0;
    if (timed && !accept) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_expire = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Timer absent; TMO_CYC only has meaning when the timer is built.
  assign tmo_expire = 1'b0 && (TMO_CYC > 0);
`endif

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pay_valid_d = 1'b0;
    pay_data_d  = pay_data_q;
    pay_last_d  = 1'b0;
    hdr_err_d   = 1'b0;
    tmo_d       = 1'b0;

    if (accept) begin
      case (state_q)
        S_IDLE, S_SHOW: begin
          if (rx_data == pic_bytes[0]) begin
            idx_d = 2'd1;
            cnt_d = '0;
            state_d = (HDR_LEN == 1) ? S_RECV : S_HDR_P;
          end else if (rx_data == game_bytes[0]) begin
            idx_d = 2'd1;
            state_d = (HDR_LEN == 1) ? S_GAME : S_HDR_G;
          end
        end

        S_HDR_P: begin
          if (rx_data == pic_bytes[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_RECV;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // Mismatching byte is consumed, not re-tried as a header start.
            state_d   = S_IDLE;
            idx_d     = '0;
            hdr_err_d = 1'b1;
          end
        end

        S_HDR_G: begin
          if (rx_data == game_bytes[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_GAME;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d   = S_IDLE;
            idx_d     = '0;
            hdr_err_d = 1'b1;
          end
        end

        S_RECV: begin
          pay_valid_d = 1'b1;
          pay_data_d  = rx_data;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            pay_last_d = 1'b1;
            state_d    = S_SHOW;
          end
        end

        S_GAME: begin
          if (rx_data == pic_bytes[0]) begin
            idx_d = 2'd1;
            cnt_d = '0;
            state_d = (HDR_LEN == 1) ? S_RECV : S_HDR_P;
          end else if (rx_data == SHOW_BYTE) begin
            state_d = S_SHOW;
          end else begin
            pay_valid_d = 1'b1;
            pay_data_d  = rx_data;
          end
        end

        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end else if (tmo_expire) begin
      state_d = S_IDLE;
      idx_d   = '0;
      tmo_d   = 1'b1;
    end

    // mode follows the next state so both change on the same edge.
    case (state_d)
      S_RECV:  mode_d = 2'd1;
      S_GAME:  mode_d = 2'd2;
      S_SHOW:  mode_d = 2'd3;
      default: mode_d = 2'd0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      // Reset high so an rx_done held high through reset release is not
      // seen as a rising edge.
      rx_done_q   <= 1'b1;
      rx_seen_q   <= 1'b1;
      mode_q      <= 2'd0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rx_done_q   <= rx_done;
      rx_seen_q   <= rx_done_q;
      mode_q      <= mode_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_last_q  <= pay_last_d;
      hdr_err_q   <= hdr_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mode      = mode_q;
  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign pay_last  = pay_last_q;
  assign hdr_err   = hdr_err_q;
  assign tmo       = tmo_q;

endmodule

// File: tb/tb_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_cmd_parser
//
// Directed bench for cmd_parser with HDR_LEN=3, PAY_LEN=4, TMO_CYC=100.
// A transaction-level model (header match position, payload byte count,
// idle-cycle count) predicts every output on every cycle; hand-computed
// literal checks pin the model at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_cmd_parser;

  localparam int PAY = 4;
  localparam int TMO = 100;
`ifdef CMD_PARSER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [1:0] mode;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic       pay_last;
  logic       hdr_err;
  logic       tmo;

  cmd_parser #(
    .DATA_W   (8),
    .HDR_LEN  (3),
    .HDR_PIC  (24'hAABBCC),
    .HDR_GAME (24'hEEDDCC),
    .SHOW_BYTE(8'hFF),
    .PAY_LEN  (PAY),
    .TMO_CYC  (TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .mode     (mode),
    .pay_valid(pay_valid),
    .pay_data (pay_data),
    .pay_last (pay_last),
    .hdr_err  (hdr_err),
    .tmo      (tmo)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  localparam int W_WAIT = 0;  // READY or SHOW, looking for a header start
  localparam int W_HDR  = 1;  // part-way through a header
  localparam int W_PAY  = 2;  // picture payload
  localparam int W_GAME = 3;  // game forwarding

  int         m_where   = W_WAIT;
  int         m_kind    = 0;   // 1 picture, 2 game
  int         m_matched = 0;   // header bytes matched so far
  int         m_paid    = 0;   // payload bytes delivered
  int         m_idle    = 0;   // byte-less cycles in a timed phase
  bit         m_s1      = 1'b1;
  bit         m_s2      = 1'b1;
  bit         started   = 1'b0;
  logic [1:0] e_mode    = 2'd0;
  logic       e_pv      = 1'b0;
  logic [7:0] e_data    = 8'h00;
  logic       e_last    = 1'b0;
  logic       e_err     = 1'b0;
  logic       e_tmo     = 1'b0;

  function automatic logic [7:0] hb(input int kind, input int i);
    logic [23:0] h;
    h = (kind == 1) ? 24'hAABBCC : 24'hEEDDCC;
    return h[8*(2-i) +: 8];
  endfunction

  task automatic m_header_done();
    if (m_kind == 1) begin
      m_where = W_PAY; m_paid = 0; e_mode = 2'd1;
    end else begin
      m_where = W_GAME; e_mode = 2'd2;
    end
  endtask

  task automatic m_try_start(input logic [7:0] b);
    if (b == hb(1, 0)) begin
      m_kind = 1; m_matched = 1; m_where = W_HDR; e_mode = 2'd0;
    end else if (b == hb(2, 0)) begin
      m_kind = 2; m_matched = 1; m_where = W_HDR; e_mode = 2'd0;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    case (m_where)
      W_WAIT: m_try_start(b);
      W_HDR: begin
        if (b == hb(m_kind, m_matched)) begin
          m_matched++;
          if (m_matched == 3) m_header_done();
        end else begin
          m_where = W_WAIT; e_mode = 2'd0; e_err = 1'b1;
        end
      end
      W_PAY: begin
        e_pv = 1'b1; e_data = b; m_paid++;
        if (m_paid == PAY) begin
          e_last = 1'b1; m_where = W_WAIT; e_mode = 2'd3;
        end
      end
      default: begin
        if (b == hb(1, 0)) m_try_start(b);
        else if (b == 8'hFF) begin
          m_where = W_WAIT; e_mode = 2'd3;
        end else begin
          e_pv = 1'b1; e_data = b;
        end
      end
    endcase
  endtask

  always @(posedge sys_clk) begin
    bit acc;
    if (sys_rst) begin
      started = 1'b1;
      m_where = W_WAIT; m_kind = 0; m_matched = 0; m_paid = 0; m_idle = 0;
      m_s1 = 1'b1; m_s2 = 1'b1;
      e_mode = 2'd0; e_pv = 1'b0; e_data = 8'h00;
      e_last = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
    end else begin
      acc = m_s1 && !m_s2;
      m_s2 = m_s1;
      m_s1 = rx_done;
      e_pv = 1'b0; e_last = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
      if (acc) begin
        m_idle = 0;
        m_byte(rx_data);
      end else if (m_where == W_HDR || m_where == W_PAY) begin
        m_idle++;
        if (TMO_EN && m_idle == TMO) begin
          m_where = W_WAIT; e_mode = 2'd0; e_tmo = 1'b1; m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  logic [7:0] obs_pay[$];
  int         obs_last_cnt = 0;
  logic [7:0] obs_last_byte = 8'h00;
  int         obs_err_cnt = 0;
  int         obs_tmo_cnt = 0;

  always @(negedge sys_clk) begin
    if (started) begin
      n_cmp++;
      if ({mode, pay_valid, pay_data, pay_last, hdr_err, tmo} !==
          {e_mode, e_pv, e_data, e_last, e_err, e_tmo}) begin
        n_bad++;
        $display("FAIL outputs t=%0t got mode=%0d pv=%0b data=%02h last=%0b err=%0b tmo=%0b want mode=%0d pv=%0b data=%02h last=%0b err=%0b tmo=%0b",
                 $time, mode, pay_valid, pay_data, pay_last, hdr_err, tmo,
                 e_mode, e_pv, e_data, e_last, e_err, e_tmo);
      end
      if (pay_valid === 1'b1) obs_pay.push_back(pay_data);
      if (pay_last === 1'b1) begin
        obs_last_cnt++;
        obs_last_byte = pay_data;
      end
      if (hdr_err === 1'b1) obs_err_cnt++;
      if (tmo === 1'b1) obs_tmo_cnt++;
    end
  end

  // ---------------- stimulus + literal checks ----------------
  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Called at a falling edge; byte is accepted two rising edges later.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    repeat (2) @(negedge sys_clk);
    rx_done = 1'b0;
    @(negedge sys_clk);
    $display("tx   byte %02h mode=%0d", b, mode);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset_mode", int'(mode), 0);
    chk("reset_flags", int'({pay_valid, pay_last, hdr_err, tmo}), 0);
    chk("reset_data", int'(pay_data), 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Picture transfer
    send3(8'hAA, 8'hBB, 8'hCC);
    chk("pic_hdr_mode", int'(mode), 1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("pic_count", obs_pay.size(), 4);
    if (obs_pay.size() == 4)
      chk("pic_bytes", int'({obs_pay[0], obs_pay[1], obs_pay[2], obs_pay[3]}), 32'h11223344);
    chk("pic_last_cnt", obs_last_cnt, 1);
    chk("pic_last_byte", int'(obs_last_byte), 8'h44);
    chk("pic_show_mode", int'(mode), 3);

    // Game mode
    obs_pay.delete();
    send3(8'hEE, 8'hDD, 8'hCC);
    chk("game_mode", int'(mode), 2);
    send(8'h05);
    send(8'hFF);
    chk("game_show_mode", int'(mode), 3);
    chk("game_fwd_count", obs_pay.size(), 1);
    if (obs_pay.size() == 1) chk("game_fwd_byte", int'(obs_pay[0]), 8'h05);

    // Header mismatch, then recovery
    send3(8'hAA, 8'hBB, 8'h12);
    chk("err_cnt1", obs_err_cnt, 1);
    chk("err_mode", int'(mode), 0);
    send3(8'hAA, 8'hBB, 8'hCC);
    chk("recover_mode", int'(mode), 1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("recover_show", int'(mode), 3);

    // Mismatching AA is consumed: following BB CC must not complete a header
    send3(8'hAA, 8'hBB, 8'hAA);
    chk("err_cnt2", obs_err_cnt, 2);
    send(8'hBB); send(8'hCC);
    chk("no_reeval_mode", int'(mode), 0);

    // Game straight into picture header
    send3(8'hEE, 8'hDD, 8'hCC);
    send3(8'hAA, 8'hBB, 8'hCC);
    chk("game_to_pic_mode", int'(mode), 1);

    // Timeout abort after one payload byte
    send(8'h11);
    repeat (100) @(negedge sys_clk);
    chk("tmo_last_cnt", obs_last_cnt, 2);
    if (TMO_EN) begin
      chk("tmo_cnt", obs_tmo_cnt, 1);
      chk("tmo_mode", int'(mode), 0);
    end else begin
      chk("notmo_cnt", obs_tmo_cnt, 0);
      chk("notmo_mode", int'(mode), 1);
      send(8'h22); send(8'h33); send(8'h44);
    end

    // Byte landing exactly on the expiry cycle wins over the timeout
    send3(8'hAA, 8'hBB, 8'hCC);
    send(8'h11);
    repeat (97) @(negedge sys_clk);
    send(8'h22);
    chk("expiry_tmo_cnt", obs_tmo_cnt, TMO_EN ? 1 : 0);
    chk("expiry_mode", int'(mode), 1);
    send(8'h33); send(8'h44);
    chk("expiry_show", int'(mode), 3);

    // Reset mid-payload with rx_done held high across release
    send3(8'hAA, 8'hBB, 8'hCC);
    send(8'h01); send(8'h02);
    obs_pay.delete();
    rx_data = 8'h03;
    rx_done = 1'b1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid_outs", int'({mode, pay_valid, pay_data, pay_last, hdr_err, tmo}), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("rst_release_pay", obs_pay.size(), 0);
    chk("rst_release_mode", int'(mode), 0);
    rx_done = 1'b0;
    @(negedge sys_clk);
    send3(8'hAA, 8'hBB, 8'hCC);
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    chk("post_rst_pay", obs_pay.size(), 4);
    chk("post_rst_last", int'(obs_last_byte), 8'h0D);
    chk("post_rst_mode", int'(mode), 3);

    repeat (3) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
